fft_stage_sequencer: RTL and testbench
======================================

# fft_stage_sequencer

Control block for the in-place radix-2 decimation-in-time FFT engine. On a start request it drives one butterfly per cycle through the shared `butterfly_unit`, and walks every stage of an N = 2^LOG2N transform. For each butterfly it generates the data-RAM read addresses, the twiddle-ROM address and a delayed write-back strobe with matching addresses. Between stages it drains the butterfly pipeline so read-after-write hazards are impossible. Data RAM must hold the input in bit-reversed order before start; results are in natural order at done.

## Interface
- LOG2N, default 3: log2 of transform length N; legal range 2..10.
- BF_LATENCY, default 2: clock cycles from butterfly inputs to butterfly outputs (multiplier stage plus adder stage).
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- i_start  input  1  start request, sampled only in IDLE.
- o_busy  output  1  high in ISSUE, DRAIN and DONE.
- o_done  output  1  one-cycle pulse when the final write-back has completed.
- o_stage  output  4  current stage index s, 0..LOG2N-1.
- o_rd_en  output  1  read strobe for both data-RAM ports.
- o_rd_addr_a  output  LOG2N  top (a) operand address.
- o_rd_addr_b  output  LOG2N  bottom (b) operand address.
- o_tw_addr  output  LOG2N-1  twiddle ROM index, W_N^index.
- o_wr_en  output  1  write-back strobe for both data-RAM ports.
- o_wr_addr_a  output  LOG2N  write address for butterfly output a.
- o_wr_addr_b  output  LOG2N  write address for butterfly output b.

## Operation
- All outputs are registered. Reset value of every output is 0; the state goes to IDLE.
- State machine:
  - IDLE: on i_start=1, clear s and k, go to ISSUE.
  - ISSUE: one butterfly per cycle, k = 0..N/2-1. After k = N/2-1, go to DRAIN.
  - DRAIN: wait D cycles, where D = 1 + BF_LATENCY. Then, if s < LOG2N-1, increment s, clear k and go to ISSUE; otherwise go to DONE.
  - DONE: for one cycle, then go to IDLE.
- Address generation for stage s and butterfly k:
  - half = 2^s.
  - pos = k mod half.
  - grp = k >> s.
  - addr_a = grp·2·half + pos.
  - addr_b = addr_a + half.
  - tw = pos << (LOG2N-1-s).
- All address arithmetic is unsigned and cannot overflow its port width.
- Write-back path: a D-deep shift pipeline carries rd_en, addr_a and addr_b. o_wr_en and the write addresses are exactly the read-side values delayed D cycles.
  - D covers the 1-cycle synchronous RAM read plus BF_LATENCY.
- i_start is ignored while o_busy=1; no queuing.
- rst asserted mid-operation:
  - Next cycle is IDLE with all outputs 0.
  - Write pipeline is flushed: no write-back of in-flight butterflies.
  - RAM contents are then undefined for the aborted transform.
- o_stage holds the stage being issued or drained. It returns to 0 in IDLE.

## Timing
- Cycle 0: i_start=1 sampled in IDLE.
- Stage s, with cycle length P = N/2 + D:
  - ISSUE occupies cycles 1+s·P .. s·P+N/2.
  - DRAIN occupies the following D cycles.
- The last write of each stage lands in the last DRAIN cycle. The first read of the next stage occurs the cycle after it, so write-then-read RAM behaviour suffices.
- o_rd_en is high every ISSUE cycle, with no gaps within a stage.
- o_wr_en is high for N/2 consecutive cycles per stage, each D cycles after the matching read.
- DONE/o_done occurs at cycle LOG2N·P + 1. o_busy is high from cycle 1 through that cycle inclusive. Next i_start is accepted the cycle after.
- Defaults (N=8, D=3, P=7): done at cycle 22. A back-to-back start is possible at cycle 23.

## Test plan
- Stage 0 addresses, defaults: i_start at cycle 0.
  - Reads at cycles 1-4: (a,b) = (0,1), (2,3), (4,5), (6,7), all with tw=0.
  - o_wr_en at cycles 4-7 with the same address pairs.
- Stages 1 and 2 addresses, defaults:
  - Stage 1 reads at cycles 8-11: (0,2), (1,3), (4,6), (5,7) with tw = 0, 2, 0, 2.
  - Stage 2 reads at cycles 15-18: (0,4), (1,5), (2,6), (3,7) with tw = 0, 1, 2, 3.
  - o_stage reads 1, then 2.
- Completion, defaults:
  - o_done is a single pulse at cycle 22. o_busy falls at cycle 23.
  - A second i_start at cycle 23 reproduces the identical sequence.
- Start while busy, defaults: pulse i_start at cycles 5 and 20 → no effect; done is still at cycle 22 only.
- Reset mid-run, defaults: rst at cycle 10.
  - Cycle 11: all outputs 0, state IDLE.
  - No o_wr_en afterwards.
  - A new start at cycle 12 gives done at cycle 34.
- Parameter sweep, LOG2N=4 and BF_LATENCY=4 (D=5, P=13):
  - Stage 3 tw sequence is 0..7.
  - 8 reads and 8 writes per stage.
  - Done at cycle 53.
  - A bit-reversed impulse is transformed through the real `butterfly_unit` and RAM model, and gives a flat spectrum.

Source files
------------

// File: rtl/fft_stage_sequencer_if.sv
// Control/address bus between the FFT stage sequencer and the butterfly datapath/RAM.
// The sequencer drives the master side; i_start is its only input.
interface fft_stage_sequencer_if #(
  parameter int LOG2N = 3
);
  logic             i_start;
  logic             o_busy;
  logic             o_done;
  logic [3:0]       o_stage;
  logic             o_rd_en;
  logic [LOG2N-1:0] o_rd_addr_a;
  logic [LOG2N-1:0] o_rd_addr_b;
  logic [LOG2N-2:0] o_tw_addr;
  logic             o_wr_en;
  logic [LOG2N-1:0] o_wr_addr_a;
  logic [LOG2N-1:0] o_wr_addr_b;

  modport master (
    input  i_start,
    output o_busy, o_done, o_stage, o_rd_en, o_rd_addr_a, o_rd_addr_b,
    output o_tw_addr, o_wr_en, o_wr_addr_a, o_wr_addr_b
  );

  modport slave (
    output i_start,
    input  o_busy, o_done, o_stage, o_rd_en, o_rd_addr_a, o_rd_addr_b,
    input  o_tw_addr, o_wr_en, o_wr_addr_a, o_wr_addr_b
  );
endinterface

// File: rtl/fft_stage_sequencer.sv
// In-place radix-2 DIT FFT sequencer: one butterfly per cycle, drains the butterfly pipeline
// between stages, write-back strobe/addresses are the read side delayed by 1 + BF_LATENCY.
module fft_stage_sequencer #(
  parameter int LOG2N      = 3,
  parameter int BF_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  fft_stage_sequencer_if.master bus
);
  localparam int N      = 1 << LOG2N;
  localparam int HALF_N = N / 2;
  localparam int D      = 1 + BF_LATENCY;
  localparam int KW     = LOG2N - 1;
  localparam int DW     = $clog2(D + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [3:0]      s_q, s_d;
  logic [DW-1:0]   drain_cnt_q, drain_cnt_d;

  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [3:0]       stage_q, stage_d;
  logic             rd_en_q, rd_en_d;
  logic [LOG2N-1:0] rd_addr_a_q, rd_addr_a_d;
  logic [LOG2N-1:0] rd_addr_b_q, rd_addr_b_d;
  logic [KW-1:0]    tw_q, tw_d;

  logic [D-1:0]              wr_en_pipe_q, wr_en_pipe_d;
  logic [D-1:0][LOG2N-1:0]   wr_addr_a_pipe_q, wr_addr_a_pipe_d;
  logic [D-1:0][LOG2N-1:0]   wr_addr_b_pipe_q, wr_addr_b_pipe_d;

  logic [LOG2N-1:0] k_ext, half, pos_mask, pos, addr_a, addr_b;
  logic [3:0]       tw_shift;

  // Group bits of k move up one place to leave room for the b half; low s bits are pos.
  always_comb begin
    k_ext    = {1'b0, k_q};
    half     = LOG2N'(1) << s_q;
    pos_mask = half - LOG2N'(1);
    pos      = k_ext & pos_mask;
    addr_a   = ((k_ext & ~pos_mask) << 1) | pos;
    addr_b   = addr_a + half;
    tw_shift = 4'(LOG2N - 1) - s_q;
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    s_d         = s_q;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.i_start) begin
          k_d     = '0;
          s_d     = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (k_q == KW'(HALF_N - 1)) begin
          drain_cnt_d = '0;
          state_d     = DRAIN;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      DRAIN: begin
        if (drain_cnt_q == DW'(D - 1)) begin
          if (s_q == 4'(LOG2N - 1)) begin
            state_d = DONE;
          end else begin
            s_d     = s_q + 4'd1;
            k_d     = '0;
            state_d = ISSUE;
          end
        end else begin
          drain_cnt_d = drain_cnt_q + DW'(1);
        end
      end
      DONE: begin
        s_d     = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered copies of the current state, so they trail the FSM by one cycle.
  always_comb begin
    busy_d      = (state_q != IDLE);
    done_d      = (state_q == DONE);
    stage_d     = (state_q == IDLE) ? 4'd0 : s_q;
    rd_en_d     = (state_q == ISSUE);
    rd_addr_a_d = rd_en_d ? addr_a : '0;
    rd_addr_b_d = rd_en_d ? addr_b : '0;
    tw_d        = rd_en_d ? KW'(pos << tw_shift) : '0;

    wr_en_pipe_d        = wr_en_pipe_q;
    wr_addr_a_pipe_d    = wr_addr_a_pipe_q;
    wr_addr_b_pipe_d    = wr_addr_b_pipe_q;
    wr_en_pipe_d[0]     = rd_en_q;
    wr_addr_a_pipe_d[0] = rd_addr_a_q;
    wr_addr_b_pipe_d[0] = rd_addr_b_q;
    for (int i = 1; i < D; i++) begin
      wr_en_pipe_d[i]     = wr_en_pipe_q[i-1];
      wr_addr_a_pipe_d[i] = wr_addr_a_pipe_q[i-1];
      wr_addr_b_pipe_d[i] = wr_addr_b_pipe_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      k_q              <= '0;
      s_q              <= '0;
      drain_cnt_q      <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      stage_q          <= '0;
      rd_en_q          <= 1'b0;
      rd_addr_a_q      <= '0;
      rd_addr_b_q      <= '0;
      tw_q             <= '0;
      wr_en_pipe_q     <= '0;
      wr_addr_a_pipe_q <= '0;
      wr_addr_b_pipe_q <= '0;
    end else begin
      state_q          <= state_d;
      k_q              <= k_d;
      s_q              <= s_d;
      drain_cnt_q      <= drain_cnt_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      stage_q          <= stage_d;
      rd_en_q          <= rd_en_d;
      rd_addr_a_q      <= rd_addr_a_d;
      rd_addr_b_q      <= rd_addr_b_d;
      tw_q             <= tw_d;
      wr_en_pipe_q     <= wr_en_pipe_d;
      wr_addr_a_pipe_q <= wr_addr_a_pipe_d;
      wr_addr_b_pipe_q <= wr_addr_b_pipe_d;
    end
  end

  assign bus.o_busy      = busy_q;
  assign bus.o_done      = done_q;
  assign bus.o_stage     = stage_q;
  assign bus.o_rd_en     = rd_en_q;
  assign bus.o_rd_addr_a = rd_addr_a_q;
  assign bus.o_rd_addr_b = rd_addr_b_q;
  assign bus.o_tw_addr   = tw_q;
  assign bus.o_wr_en     = wr_en_pipe_q[D-1];
  assign bus.o_wr_addr_a = wr_addr_a_pipe_q[D-1];
  assign bus.o_wr_addr_b = wr_addr_b_pipe_q[D-1];
endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Bench for fft_stage_sequencer: default instance (N=8, D=3) and a sweep instance (N=16, D=5)
// checked every cycle against a timeline model, plus literal address tables and a real-valued FFT.
module tb_fft_stage_sequencer;
  localparam int LGA = 3, BLA = 2, DA = 1 + BLA;
  localparam int LGB = 4, BLB = 4, DB = 1 + BLB;
  localparam int LAST_A = LGA * ((1 << LGA) / 2 + DA) + 1;
  localparam int LAST_B = LGB * ((1 << LGB) / 2 + DB) + 1;
  localparam int T1 = 10, T2 = T1 + 23, T3 = T2 + 30, TB0 = 5;
  localparam int CHK_T = 105, END_T = 110;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [3:0] stage;
    logic       rd_en;
    logic [9:0] ra;
    logic [9:0] rb;
    logic [9:0] tw;
    logic       wr_en;
    logic [9:0] wa;
    logic [9:0] wb;
  } obs_t;

  typedef struct {
    real ar, ai, br, bi;
  } bf_t;

  logic clk = 1'b0;
  logic rst_a, rst_b, start_a, start_b;
  int   edge_n = -1;
  int   st_a = -1, st_b = -1, runs_a = 0;
  int   checks = 0, failures = 0;

  int lit_c [12] = '{1, 2, 3, 4, 8, 9, 10, 11, 15, 16, 17, 18};
  int lit_a [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int lit_b [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  int lit_tw[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
  int lit_s [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2};

  fft_stage_sequencer_if #(.LOG2N(LGA)) bus_a ();
  fft_stage_sequencer_if #(.LOG2N(LGB)) bus_b ();
  assign bus_a.i_start = start_a;
  assign bus_b.i_start = start_b;

  fft_stage_sequencer #(.LOG2N(LGA), .BF_LATENCY(BLA)) dut_a (.clk(clk), .rst(rst_a), .bus(bus_a));
  fft_stage_sequencer #(.LOG2N(LGB), .BF_LATENCY(BLB)) dut_b (.clk(clk), .rst(rst_b), .bus(bus_b));

  always #5 clk = ~clk;

  function automatic void bf_addr(input int lg, input int s, input int k,
                                  output int a, output int b, output int tw);
    int half;
    half = 1 << s;
    a  = (k / half) * 2 * half + (k % half);
    b  = a + half;
    tw = (k % half) * (1 << (lg - 1 - s));
  endfunction

  // c = cycles since the accepted start edge; -1 or out of range means idle.
  function automatic obs_t model(input int lg, input int d, input int c);
    obs_t e;
    int hn, p, last, a, b, tw;
    e = '0;
    hn = (1 << lg) / 2;
    p = hn + d;
    last = lg * p + 1;
    if (c >= 1 && c <= last) begin
      e.busy  = 1'b1;
      e.done  = (c == last);
      e.stage = 4'((c == last) ? lg - 1 : (c - 1) / p);
      if (c < last && (c - 1) % p < hn) begin
        bf_addr(lg, (c - 1) / p, (c - 1) % p, a, b, tw);
        e.rd_en = 1'b1;
        e.ra = 10'(a);
        e.rb = 10'(b);
        e.tw = 10'(tw);
      end
      if (c - d >= 1 && c - d < last && (c - d - 1) % p < hn) begin
        bf_addr(lg, (c - d - 1) / p, (c - d - 1) % p, a, b, tw);
        e.wr_en = 1'b1;
        e.wa = 10'(a);
        e.wb = 10'(b);
      end
    end
    return e;
  endfunction

  // Start acceptance and reset as seen at each rising edge.
  always @(posedge clk) begin
    edge_n = edge_n + 1;
    if (rst_a) st_a = -1;
    else if (start_a && (st_a < 0 || edge_n - st_a >= LAST_A + 1)) begin
      st_a = edge_n;
      runs_a = runs_a + 1;
    end
    if (rst_b) st_b = -1;
    else if (start_b && (st_b < 0 || edge_n - st_b >= LAST_B + 1)) st_b = edge_n;
  end

  real re_m[16], im_m[16];
  bf_t bfq[$];
  int  done_a[$], tw3[$];
  int  rdcnt[4];
  int  wrcnt = 0, done_b_t = -1;

  always @(negedge clk) begin
    obs_t ea, aa, eb, ab;
    bf_t  bf;
    int   t, ca, cb, bad;
    real  wr, wi, pr, pi;
    t  = edge_n;
    ca = (st_a < 0) ? -1 : t - st_a;
    cb = (st_b < 0) ? -1 : t - st_b;

    aa = '0;
    aa.busy = bus_a.o_busy;  aa.done = bus_a.o_done;  aa.stage = bus_a.o_stage;
    aa.rd_en = bus_a.o_rd_en; aa.ra = 10'(bus_a.o_rd_addr_a); aa.rb = 10'(bus_a.o_rd_addr_b);
    aa.tw = 10'(bus_a.o_tw_addr); aa.wr_en = bus_a.o_wr_en;
    aa.wa = 10'(bus_a.o_wr_addr_a); aa.wb = 10'(bus_a.o_wr_addr_b);
    ab = '0;
    ab.busy = bus_b.o_busy;  ab.done = bus_b.o_done;  ab.stage = bus_b.o_stage;
    ab.rd_en = bus_b.o_rd_en; ab.ra = 10'(bus_b.o_rd_addr_a); ab.rb = 10'(bus_b.o_rd_addr_b);
    ab.tw = 10'(bus_b.o_tw_addr); ab.wr_en = bus_b.o_wr_en;
    ab.wa = 10'(bus_b.o_wr_addr_a); ab.wb = 10'(bus_b.o_wr_addr_b);

    ea = model(LGA, DA, ca);
    eb = model(LGB, DB, cb);
    checks++;
    if (aa !== ea) begin
      failures++;
      $display("FAIL model_a t=%0d actual=%h required=%h", t, aa, ea);
    end
    checks++;
    if (ab !== eb) begin
      failures++;
      $display("FAIL model_b t=%0d actual=%h required=%h", t, ab, eb);
    end

    // Literal expectations for the first default run.
    if (runs_a == 1 && st_a == T1) begin
      for (int i = 0; i < 12; i++) begin
        if (ca == lit_c[i]) begin
          checks++;
          if (aa.rd_en !== 1'b1 || aa.ra != 10'(lit_a[i]) || aa.rb != 10'(lit_b[i]) ||
              aa.tw != 10'(lit_tw[i]) || aa.stage != 4'(lit_s[i])) begin
            failures++;
            $display("FAIL lit_rd c=%0d actual=%0d/%0d/%0d/%0d/s%0d required=1/%0d/%0d/%0d/s%0d",
                     ca, aa.rd_en, aa.ra, aa.rb, aa.tw, aa.stage, lit_a[i], lit_b[i], lit_tw[i], lit_s[i]);
          end
        end
        if (ca == lit_c[i] + 3) begin
          checks++;
          if (aa.wr_en !== 1'b1 || aa.wa != 10'(lit_a[i]) || aa.wb != 10'(lit_b[i])) begin
            failures++;
            $display("FAIL lit_wr c=%0d actual=%0d/%0d/%0d required=1/%0d/%0d",
                     ca, aa.wr_en, aa.wa, aa.wb, lit_a[i], lit_b[i]);
          end
        end
      end
    end
    if (t == T1 + 23) begin
      checks++;
      if (aa.busy !== 1'b0) begin
        failures++;
        $display("FAIL busy_fall t=%0d actual=%0d required=0", t, aa.busy);
      end
    end
    if (t == T3 + 11) begin
      checks++;
      if (aa !== '0) begin
        failures++;
        $display("FAIL reset_mid t=%0d actual=%h required=0", t, aa);
      end
    end
    if (bus_a.o_done === 1'b1) done_a.push_back(t);

    // Sweep instance: RAM plus real-valued butterfly, writes before reads in a cycle.
    if (t == 0) begin
      for (int i = 0; i < 16; i++) begin
        re_m[i] = 0.0;
        im_m[i] = 0.0;
      end
      re_m[0] = 1.0;
    end
    if (bus_b.o_wr_en === 1'b1) begin
      wrcnt++;
      if (bfq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL bf_queue t=%0d actual=empty required=pending", t);
      end else begin
        bf = bfq.pop_front();
        re_m[bus_b.o_wr_addr_a] = bf.ar;
        im_m[bus_b.o_wr_addr_a] = bf.ai;
        re_m[bus_b.o_wr_addr_b] = bf.br;
        im_m[bus_b.o_wr_addr_b] = bf.bi;
      end
    end
    if (bus_b.o_rd_en === 1'b1) begin
      if (bus_b.o_stage < 4) rdcnt[bus_b.o_stage]++;
      if (bus_b.o_stage == 4'd3) tw3.push_back(int'(bus_b.o_tw_addr));
      wr = $cos(2.0 * 3.14159265358979 * real'(bus_b.o_tw_addr) / 16.0);
      wi = -$sin(2.0 * 3.14159265358979 * real'(bus_b.o_tw_addr) / 16.0);
      pr = re_m[bus_b.o_rd_addr_b] * wr - im_m[bus_b.o_rd_addr_b] * wi;
      pi = re_m[bus_b.o_rd_addr_b] * wi + im_m[bus_b.o_rd_addr_b] * wr;
      bf.ar = re_m[bus_b.o_rd_addr_a] + pr;
      bf.ai = im_m[bus_b.o_rd_addr_a] + pi;
      bf.br = re_m[bus_b.o_rd_addr_a] - pr;
      bf.bi = im_m[bus_b.o_rd_addr_a] - pi;
      bfq.push_back(bf);
    end
    if (bus_b.o_done === 1'b1) done_b_t = t;

    if (t == CHK_T) begin
      checks++;
      if (done_a.size() != 3 || done_a[0] != T1 + 22 || done_a[1] != T2 + 22 || done_a[2] != T3 + 34) begin
        failures++;
        $display("FAIL done_a_cycles actual=%p required=%0d,%0d,%0d", done_a, T1 + 22, T2 + 22, T3 + 34);
      end
      checks++;
      if (done_b_t != TB0 + 53) begin
        failures++;
        $display("FAIL done_b_cycle actual=%0d required=%0d", done_b_t, TB0 + 53);
      end
      checks++;
      if (rdcnt[0] != 8 || rdcnt[1] != 8 || rdcnt[2] != 8 || rdcnt[3] != 8 || wrcnt != 32) begin
        failures++;
        $display("FAIL counts_b actual=rd %0d,%0d,%0d,%0d wr %0d required=rd 8 each wr 32",
                 rdcnt[0], rdcnt[1], rdcnt[2], rdcnt[3], wrcnt);
      end
      bad = (tw3.size() != 8) ? 1 : 0;
      for (int i = 0; i < tw3.size(); i++) if (tw3[i] != i) bad = 1;
      checks++;
      if (bad != 0) begin
        failures++;
        $display("FAIL tw_stage3 actual=%p required=0..7", tw3);
      end
      bad = 0;
      for (int i = 0; i < 16; i++)
        if (re_m[i] > 1.000001 || re_m[i] < 0.999999 || im_m[i] > 0.000001 || im_m[i] < -0.000001)
          bad = bad + 1;
      checks++;
      if (bad != 0) begin
        failures++;
        $display("FAIL flat_spectrum actual=%0d bins off required=0 (bin1 %f,%f)", bad, re_m[1], im_m[1]);
      end
    end
  end

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    for (int e = 0; e <= END_T; e++) begin
      @(posedge clk);
      #1;
      rst_a = (e + 1 <= 2) || (e + 1 == T3 + 10);
      rst_b = (e + 1 <= 2);
      start_a = (e + 1 == T1) || (e + 1 == T1 + 5) || (e + 1 == T1 + 20) ||
                (e + 1 == T2) || (e + 1 == T3) || (e + 1 == T3 + 12);
      start_b = (e + 1 == TB0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
